avmm_sdram_arbiter: RTL
=======================

AVMM_SDRAM_ARBITER -- requirements
Module: avmm_sdram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 24, meaning word address width toward the SDRAM controller.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width; byteenable width is DATA_W/8.
REQ-003 The block SHALL have parameter MAX_RD, default 4, meaning the maximum number of outstanding reads (power of 2, 2..16).
REQ-004 The block SHALL use reset rst_in, asynchronous, active-low; clock clk_riscv.
REQ-005 The block SHALL have the port clk_riscv  input  1  system clock.
REQ-006 The block SHALL have the port rst_in  input  1  async active-low reset.
REQ-007 The block SHALL have, for N in {0,1} (0 = instruction fetch, 1 = data), the port mN_address  input  ADDR_W  master word address.
REQ-008 The block SHALL have the port mN_read  input  1  read request.
REQ-009 The block SHALL have the port mN_write  input  1  write request.
REQ-010 The block SHALL have the port mN_writedata  input  DATA_W  write data.
REQ-011 The block SHALL have the port mN_byteenable  input  DATA_W/8  byte lanes.
REQ-012 The block SHALL have the port mN_waitrequest  output  1  command not accepted.
REQ-013 The block SHALL have the port mN_readdata  output  DATA_W  returned read data.
REQ-014 The block SHALL have the port mN_readdatavalid  output  1  readdata valid.
REQ-015 The block SHALL have the slave-side ports s_address, s_read, s_write, s_writedata and s_byteenable  output  (widths as mN)  command to the SDRAM controller.
REQ-016 The block SHALL have the slave-side ports s_waitrequest, s_readdata and s_readdatavalid  input  1/DATA_W/1  controller response.
REQ-017 The block SHALL have the port rd_pending  output  $clog2(MAX_RD)+1  outstanding read count.

Function
REQ-018 The arbiter SHALL be an FSM with two states: IDLE (no lock) and LOCK (owner register holds 0 or 1).
REQ-019 In IDLE with exactly one master requesting (read|write), that master SHALL be selected combinationally in the same cycle (zero added latency).
REQ-020 In IDLE with both masters requesting, the master not equal to last_grant SHALL be selected (round-robin); last_grant SHALL be 1 after reset so m0 wins the first tie.
REQ-021 The selected command SHALL drive s_* directly; all other s_* outputs SHALL be 0 when nothing is selected.
REQ-022 A command SHALL be accepted when it is driven on s_* and s_waitrequest=0; on acceptance last_grant SHALL take the selected master and the FSM SHALL return to or stay in IDLE.
REQ-023 When a selected command is not accepted (s_waitrequest=1), the FSM SHALL go to LOCK with that owner, and the owner SHALL stay selected until acceptance, so Avalon command stability is never violated.
REQ-024 mN_waitrequest SHALL be 1 whenever master N is not selected or the selected command is not accepted, and 0 only in the cycle its command is accepted.
REQ-025 A read from a master SHALL be held (s_read masked, waitrequest=1) while rd_pending==MAX_RD; writes SHALL NOT be blocked by this condition.
REQ-026 Each accepted read SHALL push the master ID into an ID FIFO of depth MAX_RD; each s_readdatavalid SHALL pop the head entry.
REQ-027 s_readdata SHALL be routed to both mN_readdata; mN_readdatavalid SHALL equal s_readdatavalid AND (head ID==N).
REQ-028 A push and a pop in the same cycle SHALL leave rd_pending unchanged, including when the FIFO is full.
REQ-029 The FIFO pointers SHALL wrap modulo MAX_RD.
REQ-030 An s_readdatavalid arriving with an empty FIFO SHALL be dropped, with no readdatavalid to either master and no pointer change.
REQ-031 A master asserting read and write together SHALL be treated as a write.

Reset
REQ-032 On rst_in low the block SHALL asynchronously set the FSM to IDLE, last_grant=1, FIFO pointers=0 and rd_pending=0.
REQ-033 While rst_in is low, all mN_waitrequest outputs SHALL be 1 and all s_read, s_write, mN_readdatavalid SHALL be 0.
REQ-034 Reset mid-transaction SHALL discard the lock and all pending read IDs; responses arriving after reset SHALL be dropped per REQ-030.

Structure
REQ-035 The shared package kyogenrv_avmm_pkg SHALL hold the master-ID typedef (1 bit), the FSM state enum and the default parameters.
REQ-036 The ID FIFO SHALL be a separate sub-module avmm_id_fifo with push/pop/full/empty/count ports.

Verification
REQ-037 Scenario: m0 reads 0x000100 with s_waitrequest=0 -> s_read=1 in the same cycle, m0_waitrequest=0; s_readdatavalid with 0xDEADBEEF two cycles later -> m0_readdatavalid=1, m1_readdatavalid=0.
REQ-038 Scenario: both masters request continuously after reset -> grants go m0,m1,m0,m1.
REQ-039 Scenario: m1 writes 0x55AA to 0x10 while s_waitrequest=1 for 3 cycles and m0 requests meanwhile -> s_* holds the m1 command for all 4 cycles, and m0 is granted next.
REQ-040 Scenario: with MAX_RD=4, five back-to-back m1 reads and no response -> 4 accepted, 5th stalled, rd_pending=4; the first response releases the 5th in the same cycle and rd_pending stays 4.
REQ-041 Scenario: interleaved reads m0,m1,m0 -> three responses route to m0,m1,m0 in order.
REQ-042 Scenario: rst_in asserted with 2 reads pending -> rd_pending=0 at once; late s_readdatavalid produces no master readdatavalid.

Source files
------------

// File: rtl/kyogenrv_avmm_pkg.sv
// Shared types and default sizing for the KyogenRV Avalon-MM SDRAM arbiter.
package kyogenrv_avmm_pkg;

  localparam int DEF_ADDR_W = 24;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_MAX_RD = 4;

  typedef logic master_id_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/avmm_id_fifo.sv
// Small FIFO of master IDs, one entry per outstanding read, popped as read data returns.
module avmm_id_fifo
  import kyogenrv_avmm_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_RD
) (
  input  logic                   clk_riscv,
  input  logic                   rst_in,
  input  logic                   push,
  input  master_id_t             push_id,
  input  logic                   pop,
  output master_id_t             head_id,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  master_id_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head_id = mem[rd_ptr];

  always_ff @(posedge clk_riscv) begin
    if (push_ok) mem[wr_ptr] <= push_id;
  end

  always_ff @(posedge clk_riscv or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/avmm_sdram_arbiter.sv
// Two-master Avalon-MM arbiter (ifetch, data) in front of one SDRAM controller,
// with round-robin grant, command locking under waitrequest and in-order read routing.
module avmm_sdram_arbiter
  import kyogenrv_avmm_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MAX_RD = DEF_MAX_RD
) (
  input  logic                    clk_riscv,
  input  logic                    rst_in,
  input  logic [ADDR_W-1:0]       m0_address,
  input  logic                    m0_read,
  input  logic                    m0_write,
  input  logic [DATA_W-1:0]       m0_writedata,
  input  logic [DATA_W/8-1:0]     m0_byteenable,
  output logic                    m0_waitrequest,
  output logic [DATA_W-1:0]       m0_readdata,
  output logic                    m0_readdatavalid,
  input  logic [ADDR_W-1:0]       m1_address,
  input  logic                    m1_read,
  input  logic                    m1_write,
  input  logic [DATA_W-1:0]       m1_writedata,
  input  logic [DATA_W/8-1:0]     m1_byteenable,
  output logic                    m1_waitrequest,
  output logic [DATA_W-1:0]       m1_readdata,
  output logic                    m1_readdatavalid,
  output logic [ADDR_W-1:0]       s_address,
  output logic                    s_read,
  output logic                    s_write,
  output logic [DATA_W-1:0]       s_writedata,
  output logic [DATA_W/8-1:0]     s_byteenable,
  input  logic                    s_waitrequest,
  input  logic [DATA_W-1:0]       s_readdata,
  input  logic                    s_readdatavalid,
  output logic [$clog2(MAX_RD):0] rd_pending
);

  arb_state_t state;
  master_id_t owner;
  master_id_t last_grant;
  master_id_t sel;
  master_id_t head_id;
  logic       sel_valid;
  logic       sel_read;
  logic       sel_write;
  logic       req0;
  logic       req1;
  logic       accept;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop_now;
  logic       rd_blocked;

  // Reads stall only while the ID FIFO is full and nothing retires this cycle.
  // A master driving read and write together is a write, which is never blocked.
  assign pop_now    = s_readdatavalid & ~fifo_empty;
  assign rd_blocked = fifo_full & ~pop_now;
  assign req0       = rst_in & (m0_write | (m0_read & ~rd_blocked));
  assign req1       = rst_in & (m1_write | (m1_read & ~rd_blocked));

  always_comb begin
    sel       = 1'b0;
    sel_valid = 1'b0;
    if (state == LOCK) begin
      sel       = owner;
      sel_valid = owner ? req1 : req0;
    end else if (req0 && req1) begin
      sel       = ~last_grant;
      sel_valid = 1'b1;
    end else if (req1) begin
      sel       = 1'b1;
      sel_valid = 1'b1;
    end else if (req0) begin
      sel_valid = 1'b1;
    end
  end

  assign sel_write    = sel ? m1_write : m0_write;
  assign sel_read     = sel ? m1_read  : m0_read;
  assign s_write      = sel_valid & sel_write;
  assign s_read       = sel_valid & sel_read & ~sel_write;
  assign s_address    = sel_valid ? (sel ? m1_address    : m0_address)    : '0;
  assign s_writedata  = sel_valid ? (sel ? m1_writedata  : m0_writedata)  : '0;
  assign s_byteenable = sel_valid ? (sel ? m1_byteenable : m0_byteenable) : '0;

  assign accept         = sel_valid & ~s_waitrequest;
  assign m0_waitrequest = ~(accept & (sel == 1'b0));
  assign m1_waitrequest = ~(accept & (sel == 1'b1));

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = pop_now & (head_id == 1'b0);
  assign m1_readdatavalid = pop_now & (head_id == 1'b1);

  // Hold the owner until its command is taken; an abandoned command just drops the lock.
  always_ff @(posedge clk_riscv or negedge rst_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid && s_waitrequest) begin
            state <= LOCK;
            owner <= sel;
          end else if (accept) begin
            last_grant <= sel;
          end
        end
        LOCK: begin
          if (!sel_valid) begin
            state <= IDLE;
          end else if (accept) begin
            state      <= IDLE;
            last_grant <= owner;
          end
        end
      endcase
    end
  end

  avmm_id_fifo #(
    .DEPTH(MAX_RD)
  ) u_id_fifo (
    .clk_riscv(clk_riscv),
    .rst_in   (rst_in),
    .push     (accept & s_read),
    .push_id  (sel),
    .pop      (pop_now),
    .head_id  (head_id),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (rd_pending)
  );

endmodule
